// File: rtl/fxp_result_narrower.sv
// rtl/fxp_result_narrower.sv - Q16.8 to Q8.8 rounding/saturating narrower with result FIFO
//
// fxp_narrow_q16_q8 : combinational narrowing of one Q16.8 sample
//   data   in  24  signed Q16.8 value
//   shift  in   2  extra arithmetic right shift 0..3, rounded half up
//   result out 16  signed Q8.8 value, clamped to the 16-bit range
//   sat    out  1  result was clamped
//
// fxp_result_narrower : narrower in front of a DEPTH-entry result FIFO
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready depends on registers only
//   in_data/in_ovf        Q16.8 result and its upstream overflow flag
//   in_shift              extra right shift applied before narrowing
//   out_valid/out_ready   downstream handshake for the FIFO head
//   out_data/out_flag     head entry (Q8.8, overflow-or-saturation); 0 when empty
//   sat_count             saturating count of entries that were clamped
//   clr_stats             clears sat_count

module fxp_narrow_q16_q8 (
    input  logic [23:0] data,
    input  logic [1:0]  shift,
    output logic [15:0] result,
    output logic        sat
);

    localparam logic signed [24:0] T_MAX = 25'sd32767;
    localparam logic signed [24:0] T_MIN = -25'sd32768;

    logic signed [24:0] wide;
    logic signed [24:0] rnd;
    logic signed [24:0] t;

    always_comb begin
        // One guard bit so that +2^(s-1) on the most positive input cannot wrap.
        wide = {data[23], data};
        case (shift)
            2'd1:    rnd = 25'sd1;
            2'd2:    rnd = 25'sd2;
            2'd3:    rnd = 25'sd4;
            default: rnd = 25'sd0;
        endcase
        // Adding half an LSB then flooring gives round-half-up toward +inf.
        t = (wide + rnd) >>> shift;

        if (t > T_MAX) begin
            result = 16'h7FFF;
            sat    = 1'b1;
        end else if (t < T_MIN) begin
            result = 16'h8000;
            sat    = 1'b1;
        end else begin
            result = t[15:0];
            sat    = 1'b0;
        end
    end

endmodule

module fxp_result_narrower #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_ovf,
    input  logic [1:0]  in_shift,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_flag,
    output logic [7:0]  sat_count,
    input  logic        clr_stats
);

    // DEPTH is a power of two, so pointers wrap modulo DEPTH by plain overflow.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry layout: {flag, data[15:0]}
    logic [16:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [15:0] narrow_data;
    logic        narrow_sat;
    logic        push;
    logic        pop;

    fxp_narrow_q16_q8 u_narrow (
        .data   (in_data),
        .shift  (in_shift),
        .result (narrow_data),
        .sat    (narrow_sat)
    );

    // Handshake status comes straight from the occupancy register, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The empty gate keeps never-written storage off the outputs.
    always_comb begin
        out_data = 16'h0000;
        out_flag = 1'b0;
        if (out_valid) begin
            out_data = mem[rd_ptr][15:0];
            out_flag = mem[rd_ptr][16];
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_ovf | narrow_sat, narrow_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear beats a same-cycle increment; in_ovf alone never counts.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_count <= 8'd0;
        end else if (push && narrow_sat && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fxp_result_narrower.sv
// tb/tb_fxp_result_narrower.sv - directed self-checking bench for fxp_result_narrower

module tb_fxp_result_narrower;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_ovf;
    logic [1:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_flag;
    logic [7:0]  sat_count;
    logic        clr_stats;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fxp_result_narrower #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .sat_count (sat_count),
        .clr_stats (clr_stats)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [23:0] d, input logic o, input logic [1:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        in_shift = s;
        tick();
        in_valid = 1'b0;
        in_ovf   = 1'b0;
        in_shift = 2'd0;
    endtask

    task automatic drive_pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; in_shift = 2'd0;
        out_ready = 1'b0; clr_stats = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, out_flag, out_data, sat_count} !== {1'b0, 1'b1, 1'b0, 16'h0000, 8'h00})
            $display("FAIL reset_state: got v=%b r=%b f=%b d=%h s=%0d expected v=0 r=1 f=0 d=0000 s=0",
                     out_valid, in_ready, out_flag, out_data, sat_count);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        drive_push(24'h000180, 1'b0, 2'd0);
        total_cnt++;
        if ({out_valid, out_flag, out_data} !== {1'b1, 1'b0, 16'h0180})
            $display("FAIL basic_head: got v=%b f=%b d=%h expected v=1 f=0 d=0180", out_valid, out_flag, out_data);
        else pass_cnt++;
        drive_pop();
        total_cnt++;
        if ({out_valid, out_flag, out_data, in_ready} !== {1'b0, 1'b0, 16'h0000, 1'b1})
            $display("FAIL basic_empty: got v=%b f=%b d=%h r=%b expected v=0 f=0 d=0000 r=1",
                     out_valid, out_flag, out_data, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        drive_push(24'h012C00, 1'b0, 2'd0);
        total_cnt++;
        if ({out_valid, out_flag, out_data, sat_count} !== {1'b1, 1'b1, 16'h7FFF, 8'd1})
            $display("FAIL sat_pos: got f=%b d=%h s=%0d expected f=1 d=7fff s=1", out_flag, out_data, sat_count);
        else pass_cnt++;
        drive_pop();
        drive_push(24'hFF0000, 1'b0, 2'd0);
        total_cnt++;
        if ({out_valid, out_flag, out_data, sat_count} !== {1'b1, 1'b1, 16'h8000, 8'd2})
            $display("FAIL sat_neg: got f=%b d=%h s=%0d expected f=1 d=8000 s=2", out_flag, out_data, sat_count);
        else pass_cnt++;
        drive_pop();
        drive_push(24'h000100, 1'b1, 2'd0);
        total_cnt++;
        if ({out_valid, out_flag, out_data, sat_count} !== {1'b1, 1'b1, 16'h0100, 8'd2})
            $display("FAIL ovf_passthru: got f=%b d=%h s=%0d expected f=1 d=0100 s=2", out_flag, out_data, sat_count);
        else pass_cnt++;
        drive_pop();
    endtask

    task automatic test_rounding();
        logic [23:0] vd [9] = '{24'h000003, 24'hFFFFFD, 24'h012C00, 24'h7FFFFF, 24'h007FFF,
                                24'hFF8000, 24'h008000, 24'h800000, 24'hFFFFFA};
        logic [1:0]  vs [9] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2};
        logic [15:0] ed [9] = '{16'h0002, 16'hFFFF, 16'h4B00, 16'h7FFF, 16'h7FFF,
                                16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic        ef [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive_push(vd[i], 1'b0, vs[i]);
            total_cnt++;
            if ({out_valid, out_flag, out_data} !== {1'b1, ef[i], ed[i]})
                $display("FAIL round_vec%0d: in=%h s=%0d got v=%b f=%b d=%h expected v=1 f=%b d=%h",
                         i, vd[i], vs[i], out_valid, out_flag, out_data, ef[i], ed[i]);
            else pass_cnt++;
            drive_pop();
        end
        total_cnt++;
        if (sat_count !== 8'd5)
            $display("FAIL round_satcount: got %0d expected 5", sat_count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1;
            in_data  = 24'((i + 1) * 256);
            tick();
            total_cnt++;
            if (in_ready !== ((i + 1) < DEPTH))
                $display("FAIL full_ready%0d: got %b expected %b", i, in_ready, ((i + 1) < DEPTH));
            else pass_cnt++;
        end
        // Pop while full: push must be refused, slot frees next cycle.
        in_data   = 24'h00EE00;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'h0200})
            $display("FAIL full_pop: got r=%b v=%b d=%h expected r=1 v=1 d=0200", in_ready, out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            total_cnt++;
            if ({out_valid, out_data} !== {1'b1, 16'((i + 1) * 256)})
                $display("FAIL full_drain%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 16'((i + 1) * 256));
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, out_data} !== {1'b0, 16'h0000})
            $display("FAIL full_empty: got v=%b d=%h expected v=0 d=0000", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        out_ready = 1'b0;
        drive_push(24'h000011, 1'b0, 2'd0);
        drive_push(24'h000022, 1'b0, 2'd0);
        q.push_back(16'h0011);
        q.push_back(16'h0022);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 24'(16'h0100 + k);
            tick();
            void'(q.pop_front());
            q.push_back(16'(16'h0100 + k));
            total_cnt++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, q[0]})
                $display("FAIL b2b_cycle%0d: got v=%b r=%b d=%h expected v=1 r=1 d=%h",
                         k, out_valid, in_ready, out_data, q[0]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            total_cnt++;
            if ({out_valid, out_data} !== {1'b1, q[0]})
                $display("FAIL b2b_drain%0d: got v=%b d=%h expected v=1 d=%h", n, out_valid, out_data, q[0]);
            else pass_cnt++;
            void'(q.pop_front());
            tick();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_empty: got v=%b expected v=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_sat_count();
        in_valid  = 1'b1;
        in_data   = 24'h012C00;
        out_ready = 1'b1;
        repeat (100) tick();
        total_cnt++;
        if (sat_count !== 8'd105)
            $display("FAIL satcnt_mid: got %0d expected 105", sat_count);
        else pass_cnt++;
        repeat (156) tick();
        total_cnt++;
        if (sat_count !== 8'd255)
            $display("FAIL satcnt_max: got %0d expected 255", sat_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (sat_count !== 8'd255)
            $display("FAIL satcnt_hold: got %0d expected 255", sat_count);
        else pass_cnt++;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        total_cnt++;
        if (sat_count !== 8'd0)
            $display("FAIL satcnt_clr: got %0d expected 0", sat_count);
        else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, sat_count} !== {1'b0, 8'd0})
            $display("FAIL satcnt_after: got v=%b s=%0d expected v=0 s=0", out_valid, sat_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_push(24'h000100, 1'b0, 2'd0);
        drive_push(24'h012C00, 1'b0, 2'd0);
        drive_push(24'h000300, 1'b0, 2'd0);
        total_cnt++;
        if ({out_valid, out_data, sat_count} !== {1'b1, 16'h0100, 8'd1})
            $display("FAIL rstmid_pre: got v=%b d=%h s=%0d expected v=1 d=0100 s=1", out_valid, out_data, sat_count);
        else pass_cnt++;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'h012C00;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_data, out_flag, sat_count, in_ready} !== {1'b0, 16'h0000, 1'b0, 8'd0, 1'b1})
            $display("FAIL rstmid_post: got v=%b d=%h f=%b s=%0d r=%b expected v=0 d=0000 f=0 s=0 r=1",
                     out_valid, out_data, out_flag, sat_count, in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, sat_count} !== {1'b0, 8'd0})
            $display("FAIL rstmid_settle: got v=%b s=%0d expected v=0 s=0", out_valid, sat_count);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_full();
        test_back_to_back();
        test_sat_count();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
